// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and address/byte helpers for the MEM-stage cache.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } mem_state_t;

    function automatic logic [31:0] get_index(input logic [31:0] addr,
                                              input int unsigned idx_bits);
        return (addr >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] addr,
                                            input int unsigned idx_bits);
        return addr >> (idx_bits + 2);
    endfunction

    // Little-endian lane select, zero-extended to a full word.
    function automatic logic [31:0] byte_select(input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return {24'd0, shifted[7:0]};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [7:0]  data,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        mask = 32'h0000_00FF << {lane, 3'b000};
        return (word & ~mask) | ({24'd0, data} << {lane, 3'b000});
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_if
// Description : EX/MEM request, stall/load-data return and main-memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;

    logic        req_valid;
    logic        req_store;
    logic        is_word;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // The master side is the pipeline plus the main memory it fronts.
    modport master (
        output req_valid, req_store, is_word, addr, wdata, mem_rdata,
        input  lock, load_data, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_store, is_word, addr, wdata, mem_rdata,
        output lock, load_data, mem_addr, mem_wdata, mem_we
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : Direct-mapped tag/data/valid/dirty storage, one write port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array #(
    parameter int LINES = 16,
    parameter int IDXW  = 4,
    parameter int TAGW  = 26
) (
    input  wire logic            clk,
    input  wire logic            rst_b,
    input  wire logic [IDXW-1:0] idx,
    output logic      [TAGW-1:0] rd_tag,
    output logic      [31:0]     rd_data,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    input  wire logic            we,
    input  wire logic [TAGW-1:0] wr_tag,
    input  wire logic [31:0]     wr_data,
    input  wire logic            wr_valid,
    input  wire logic            wr_dirty
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we) begin
            valid_d[idx] = wr_valid;
            dirty_d[idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage write-back/write-allocate cache with pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_b,
    mem_stage_ctrl_if.slave  bus
);

    localparam int unsigned c_idx_w = $clog2(LINES);
    localparam int unsigned c_tag_w = 30 - c_idx_w;
    localparam int unsigned c_cnt_w = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_LATENCY - 1);

    mem_state_t           state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;

    logic [c_idx_w-1:0]   w_index;
    logic [c_tag_w-1:0]   w_tag;
    logic [1:0]           w_offset;
    logic                 w_hit;
    logic                 w_last;

    logic [c_tag_w-1:0]   rd_tag;
    logic [31:0]          rd_data;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic                 arr_we;
    logic [c_tag_w-1:0]   wr_tag;
    logic [31:0]          wr_data;
    logic                 wr_valid;
    logic                 wr_dirty;

    logic                 w_lock;
    logic [31:0]          w_load_data;
    logic [31:0]          w_mem_addr;
    logic [31:0]          w_mem_wdata;
    logic                 w_mem_we;

    assign w_index  = c_idx_w'(get_index(bus.addr, c_idx_w));
    assign w_tag    = c_tag_w'(get_tag(bus.addr, c_idx_w));
    assign w_offset = bus.addr[1:0];
    assign w_hit    = bus.req_valid & rd_valid & (rd_tag == w_tag);
    assign w_last   = (cnt_q == c_cnt_last);

    cache_array #(
        .LINES (LINES),
        .IDXW  (c_idx_w),
        .TAGW  (c_tag_w)
    ) u_cache_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .idx      (w_index),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .we       (arr_we),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_we      = 1'b0;
        wr_tag      = rd_tag;
        wr_data     = rd_data;
        wr_valid    = rd_valid;
        wr_dirty    = rd_dirty;
        w_lock      = 1'b0;
        w_load_data = 32'd0;
        w_mem_addr  = 32'd0;
        w_mem_wdata = 32'd0;
        w_mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_hit) begin
                        if (bus.req_store) begin
                            arr_we   = 1'b1;
                            wr_data  = bus.is_word ? bus.wdata
                                                   : byte_merge(rd_data, bus.wdata[7:0], w_offset);
                            wr_dirty = 1'b1;
                        end else begin
                            w_load_data = bus.is_word ? rd_data : byte_select(rd_data, w_offset);
                        end
                    end else begin
                        w_lock  = 1'b1;
                        cnt_d   = '0;
                        state_d = (rd_valid && rd_dirty) ? WRITEBACK : FILL;
                    end
                end
            end

            WRITEBACK: begin
                w_lock      = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {rd_tag, w_index, 2'b00};
                w_mem_wdata = rd_data;
                if (w_last) begin
                    arr_we   = 1'b1;
                    wr_dirty = 1'b0;
                    cnt_d    = '0;
                    state_d  = FILL;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end

            FILL: begin
                w_lock     = 1'b1;
                w_mem_addr = {bus.addr[31:2], 2'b00};
                // A store miss only allocates here; the merge is a hit in IDLE.
                if (w_last) begin
                    arr_we   = 1'b1;
                    wr_tag   = w_tag;
                    wr_data  = bus.mem_rdata;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are quiet for the whole reset pulse, not just after it.
        if (rst_b) begin
            arr_we      = 1'b0;
            w_lock      = 1'b0;
            w_load_data = 32'd0;
            w_mem_addr  = 32'd0;
            w_mem_wdata = 32'd0;
            w_mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.lock      = w_lock;
    assign bus.load_data = w_load_data;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_we    = w_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed self-checking bench for the MEM-stage cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk   = 1'b0;
    logic        rst_b = 1'b1;
    logic [31:0] fill_word = 32'd0;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if bus();
    assign bus.mem_rdata = fill_word;

    mem_stage_ctrl #(
        .LINES       (16),
        .MEM_LATENCY (4)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_store = st;
        bus.is_word   = w;
        bus.addr      = a;
        bus.wdata     = d;
    endtask

    // Walks a stall to completion, tallying write-back and fill bus cycles.
    task automatic run_miss(input logic [31:0] wb_addr, input logic [31:0] wb_data,
                            input logic [31:0] fill_addr,
                            output int cycles, output int we_cycles,
                            output int wb_match, output int fill_match);
        cycles = 0; we_cycles = 0; wb_match = 0; fill_match = 0;
        #1;
        while (bus.lock && cycles < 40) begin
            if (bus.mem_we) begin
                we_cycles++;
                if (bus.mem_addr == wb_addr && bus.mem_wdata == wb_data) wb_match++;
            end else if (cycles > 0 && bus.mem_addr == fill_addr) begin
                fill_match++;
            end
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c, we, wbm, fm;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_lock",      32'(bus.lock),   32'd0);
        check_eq("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check_eq("rst_load_data", bus.load_data,   32'd0);
        check_eq("rst_mem_addr",  bus.mem_addr,    32'd0);
        rst_b = 1'b0;
        tick();

        // Cold miss at 0x00
        fill_word = 32'h1122_3344;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd0);
        run_miss(32'd0, 32'd0, 32'h0000_0000, c, we, wbm, fm);
        check_eq("cold_lock_cycles", 32'(c),  32'd5);
        check_eq("cold_mem_we",      32'(we), 32'd0);
        check_eq("cold_fill_addr",   32'(fm), 32'd4);
        check_eq("cold_load_data",   bus.load_data, 32'h1122_3344);

        // Store hit then load hit
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
        #1;
        check_eq("store_hit_lock", 32'(bus.lock), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd0);
        #1;
        check_eq("load_hit_lock", 32'(bus.lock), 32'd0);
        check_eq("load_hit_data", bus.load_data, 32'hDEAD_BEEF);

        // Dirty conflict miss at 0x40
        tick();
        fill_word = 32'hCAFE_F00D;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
        run_miss(32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0040, c, we, wbm, fm);
        check_eq("dirty_lock_cycles", 32'(c),   32'd9);
        check_eq("dirty_we_cycles",   32'(we),  32'd4);
        check_eq("dirty_wb_match",    32'(wbm), 32'd4);
        check_eq("dirty_fill_match",  32'(fm),  32'd4);
        check_eq("dirty_load_data",   bus.load_data, 32'hCAFE_F00D);

        // Byte store lane 3, byte load, word load
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0043, 32'h0000_00AA);
        #1;
        check_eq("bstore_lock", 32'(bus.lock), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0043, 32'd0);
        #1;
        check_eq("bload_data", bus.load_data, 32'h0000_00AA);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
        #1;
        check_eq("wload_merged", bus.load_data, 32'hAAFE_F00D);

        // Reset in the second write-back cycle
        tick();
        fill_word = 32'h7777_7777;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd0);
        #1;
        check_eq("abort_miss_lock", 32'(bus.lock), 32'd1);
        tick();
        tick();
        check_eq("abort_wb_we",    32'(bus.mem_we), 32'd1);
        check_eq("abort_wb_addr",  bus.mem_addr,    32'h0000_0040);
        check_eq("abort_wb_wdata", bus.mem_wdata,   32'hAAFE_F00D);
        rst_b = 1'b1;
        #1;
        check_eq("abort_rst_lock",   32'(bus.lock),   32'd0);
        check_eq("abort_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("abort_rst_load",   bus.load_data,   32'd0);
        tick();
        rst_b = 1'b0;
        run_miss(32'd0, 32'd0, 32'h0000_0000, c, we, wbm, fm);
        check_eq("post_rst_lock_cycles", 32'(c),  32'd5);
        check_eq("post_rst_no_wb",       32'(we), 32'd0);
        check_eq("post_rst_load_data",   bus.load_data, 32'h7777_7777);

        // Store miss with clean victim at 0x80
        tick();
        fill_word = 32'h5555_5555;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678);
        run_miss(32'd0, 32'd0, 32'h0000_0080, c, we, wbm, fm);
        check_eq("smiss_lock_cycles", 32'(c),  32'd5);
        check_eq("smiss_mem_we",      32'(we), 32'd0);
        check_eq("smiss_fill_match",  32'(fm), 32'd4);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'd0);
        #1;
        check_eq("smiss_load_data", bus.load_data, 32'h1234_5678);

        // Evicting 0x80 proves the merged line is dirty
        tick();
        fill_word = 32'h0BAD_F00D;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd0);
        run_miss(32'h0000_0080, 32'h1234_5678, 32'h0000_0000, c, we, wbm, fm);
        check_eq("evict_lock_cycles", 32'(c),   32'd9);
        check_eq("evict_wb_match",    32'(wbm), 32'd4);
        check_eq("evict_fill_match",  32'(fm),  32'd4);
        check_eq("evict_load_data",   bus.load_data, 32'h0BAD_F00D);

        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_eq("idle_lock", 32'(bus.lock), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
